// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: function codes and FSM states.
package mdu_pkg;

    typedef enum logic [2:0] {
        MF_MULT  = 3'd0,
        MF_MULTU = 3'd1,
        MF_DIV   = 3'd2,
        MF_DIVU  = 3'd3,
        MF_MTHI  = 3'd4,
        MF_MTLO  = 3'd5
    } mf_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_e;

endpackage

// File: rtl/mdu.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Divide support is compiled in only when MDU_DIV_EN is defined.
module mdu
    import mdu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [2:0]   mf,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int CW = $clog2(N) + 1;
`ifdef MDU_DIV_EN
    localparam int AW = N + 2;
`else
    localparam int AW = N + 1;
`endif

    state_e        state;
    logic [CW-1:0] cnt;
    logic [N:0]    acc;
    logic [N-1:0]  q;
    logic [N-1:0]  bm;
    logic          neg_p;
`ifdef MDU_DIV_EN
    logic          is_div;
    logic          neg_r;
    logic          bz;
`endif

    logic          sgn;
    logic [N-1:0]  a_mag;
    logic [N-1:0]  b_mag;
    logic [AW-1:0] x;
    logic [AW-1:0] y;
    logic [AW-1:0] sum;
    logic          sub;
    logic [N:0]    s;
    logic [2*N-1:0] pm;
    logic [2*N-1:0] prod;

    assign sgn   = (mf == MF_MULT) || (mf == MF_DIV);
    assign a_mag = (sgn && a[N-1]) ? -a : a;
    assign b_mag = (sgn && b[N-1]) ? -b : b;

    // One adder serves both the multiply accumulate and the divide trial subtract.
    always_comb begin
        sub = 1'b0;
`ifdef MDU_DIV_EN
        sub = is_div;
        x   = is_div ? {1'b0, acc[N-1:0], q[N-1]} : {1'b0, acc};
`else
        x   = acc;
`endif
        y   = AW'(bm);
        sum = x + (y ^ {AW{sub}}) + AW'(sub);
        s   = q[0] ? sum[N:0] : acc;
        pm  = {acc[N-1:0], q};
        prod = neg_p ? -pm : pm;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            acc   <= '0;
            q     <= '0;
            bm    <= '0;
            neg_p <= 1'b0;
`ifdef MDU_DIV_EN
            is_div <= 1'b0;
            neg_r  <= 1'b0;
            bz     <= 1'b0;
`endif
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        case (mf)
                            MF_MULT, MF_MULTU: begin
                                acc   <= '0;
                                q     <= a_mag;
                                bm    <= b_mag;
                                neg_p <= sgn && (a[N-1] ^ b[N-1]);
                                cnt   <= '0;
`ifdef MDU_DIV_EN
                                is_div <= 1'b0;
`endif
                                busy  <= 1'b1;
                                state <= S_RUN;
                            end
`ifdef MDU_DIV_EN
                            MF_DIV, MF_DIVU: begin
                                acc    <= '0;
                                q      <= a_mag;
                                bm     <= b_mag;
                                neg_p  <= sgn && (a[N-1] ^ b[N-1]);
                                neg_r  <= sgn && a[N-1];
                                bz     <= (b == '0);
                                cnt    <= '0;
                                is_div <= 1'b1;
                                busy   <= 1'b1;
                                state  <= S_RUN;
                            end
`endif
                            MF_MTHI: begin
                                hi   <= a;
                                done <= 1'b1;
                            end
                            MF_MTLO: begin
                                lo   <= a;
                                done <= 1'b1;
                            end
                            default: begin
                                done <= 1'b1;
                                err  <= 1'b1;
                            end
                        endcase
                    end
                end
                S_RUN: begin
`ifdef MDU_DIV_EN
                    if (is_div) begin
                        // Borrow out of the trial subtract means the shifted remainder is kept.
                        if (!sum[AW-1]) begin
                            acc <= sum[N:0];
                            q   <= {q[N-2:0], 1'b1};
                        end else begin
                            acc <= x[N:0];
                            q   <= {q[N-2:0], 1'b0};
                        end
                    end else
`endif
                    begin
                        acc <= {1'b0, s[N:1]};
                        q   <= {s[0], q[N-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(N - 1))
                        state <= S_FIX;
                end
                S_FIX: begin
`ifdef MDU_DIV_EN
                    if (is_div) begin
                        lo <= bz ? '1 : (neg_p ? -q : q);
                        hi <= neg_r ? -acc[N-1:0] : acc[N-1:0];
                    end else
`endif
                    begin
                        {hi, lo} <= prod;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Directed scoreboard bench for mdu (N=32); divide expectations follow MDU_DIV_EN.
module tb_mdu;
    import mdu_pkg::*;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   mf;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         busy;
    logic         done;
    logic         err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N-1:0] hi;
        logic [N-1:0] lo;
        logic         err;
        int           lat;
        logic         longop;
    } exp_t;

    exp_t sbq[$];
    logic [N-1:0] mhi = '0;
    logic [N-1:0] mlo = '0;

    mdu #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .mf    (mf),
        .a     (a),
        .b     (b),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] f, input logic [N-1:0] x, input logic [N-1:0] y);
        exp_t e;
        logic [63:0] p;
        logic signed [N-1:0] sx;
        logic signed [N-1:0] sy;
        e.hi = mhi; e.lo = mlo; e.err = 1'b0; e.lat = 1; e.longop = 1'b0;
        sx = x; sy = y;
        case (f)
            3'd0: begin
                p = longint'(sx) * longint'(sy);
                {e.hi, e.lo} = p; e.lat = N + 2; e.longop = 1'b1;
            end
            3'd1: begin
                p = {32'b0, x} * {32'b0, y};
                {e.hi, e.lo} = p; e.lat = N + 2; e.longop = 1'b1;
            end
`ifdef MDU_DIV_EN
            3'd2, 3'd3: begin
                e.lat = N + 2; e.longop = 1'b1;
                if (y == '0) begin
                    e.lo = '1; e.hi = x;
                end else if (f == 3'd3) begin
                    e.lo = x / y; e.hi = x % y;
                end else if (x == 32'h8000_0000 && y == '1) begin
                    e.lo = x; e.hi = '0;
                end else begin
                    e.lo = sx / sy; e.hi = sx % sy;
                end
            end
`endif
            3'd4: e.hi = x;
            3'd5: e.lo = x;
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    task automatic run_op(input string tag, input logic [2:0] f, input logic [N-1:0] x,
                          input logic [N-1:0] y, input int inject);
        exp_t e;
        exp_t g;
        int k;
        e = model(f, x, y);
        sbq.push_back(e);
        mf = f; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; mf = 3'($urandom_range(0, 7));
        for (k = 1; k <= N + 4; k++) begin
            if (done) break;
            chk({tag, " busy"}, 64'(busy), 64'(e.longop));
            if (k == inject) begin
                start = 1'b1; mf = MF_MTHI; a = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk({tag, " latency"}, 64'(k), 64'(e.lat));
        chk({tag, " done"}, 64'(done), 64'd1);
        g = sbq.pop_front();
        chk({tag, " hi"}, 64'(hi), 64'(g.hi));
        chk({tag, " lo"}, 64'(lo), 64'(g.lo));
        chk({tag, " err"}, 64'(err), 64'(g.err));
        chk({tag, " busy@done"}, 64'(busy), 64'd0);
        mhi = g.hi; mlo = g.lo;
        @(posedge clk); #1;
        chk({tag, " done pulse"}, 64'(done), 64'd0);
        chk({tag, " err pulse"}, 64'(err), 64'd0);
    endtask

    initial begin
        int ndone;
        reset = 1'b1; start = 1'b0; mf = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset err", 64'(err), 64'd0);

        run_op("mult_neg",  MF_MULT,  32'h0000_0007, 32'hFFFF_FFFD, -1);
        run_op("multu_max", MF_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        run_op("mult_min",  MF_MULT,  32'h8000_0000, 32'h8000_0000, -1);
        run_op("mthi",      MF_MTHI,  32'h1234_5678, 32'h0,         -1);
        run_op("mtlo",      MF_MTLO,  32'h9ABC_DEF0, 32'h0,         -1);
        run_op("div_neg",   MF_DIV,   32'hFFFF_FFF9, 32'h0000_0002, -1);
        run_op("divu",      MF_DIVU,  32'h0000_0064, 32'h0000_0007, -1);
        run_op("divu_zero", MF_DIVU,  32'h0000_0005, 32'h0000_0000, -1);
        run_op("div_zero",  MF_DIV,   32'hFFFF_FFF0, 32'h0000_0000, -1);
        run_op("div_ovf",   MF_DIV,   32'h8000_0000, 32'hFFFF_FFFF, -1);
        run_op("rsvd6",     3'd6,     32'hAAAA_AAAA, 32'h5555_5555, -1);
        run_op("rsvd7",     3'd7,     32'h1111_1111, 32'h2222_2222, -1);
        run_op("mult_busy_start", MF_MULT, 32'hFFFF_FF00, 32'h0001_0003, 5);

        for (int i = 0; i < 6; i++)
            run_op("rand", 3'($urandom_range(0, 3)), $urandom, $urandom, -1);

        repeat (5) @(posedge clk);
        #1;
        chk("hold hi", 64'(hi), 64'(mhi));
        chk("hold lo", 64'(lo), 64'(mlo));

        // Abort a multiply in cycle t+10; a start coincident with reset must be dropped.
        mf = MF_MULT; a = 32'h0000_1234; b = 32'h0000_5678; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1; start = 1'b1; mf = MF_MTHI; a = 32'hAAAA_5555;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        chk("abort hi", 64'(hi), 64'd0);
        chk("abort lo", 64'(lo), 64'd0);
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        chk("abort err", 64'(err), 64'd0);
        ndone = 0;
        for (int i = 0; i < N + 4; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("abort no done", 64'(ndone), 64'd0);
        chk("abort hi hold", 64'(hi), 64'd0);
        mhi = '0; mlo = '0;

        run_op("post_reset_mult", MF_MULTU, 32'h0000_00FF, 32'h0000_0101, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have parameter N, default 32, meaning operand, HI and LO width (N >= 4, even).
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request strobe; sampled only while busy=0.
REQ-005 SHALL have port mf  input  3  function: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others reserved.
REQ-006 SHALL have port a  input  N  first operand (multiplicand/dividend/move source).
REQ-007 SHALL have port b  input  N  second operand (multiplier/divisor).
REQ-008 SHALL have port hi  output  N  HI register (product upper half / remainder).
REQ-009 SHALL have port lo  output  N  LO register (product lower half / quotient).
REQ-010 SHALL have port busy  output  1  operation in flight; new start ignored.
REQ-011 SHALL have port done  output  1  one-cycle pulse when hi/lo hold the new result.
REQ-012 SHALL have port err  output  1  one-cycle pulse with done for a rejected operation.

Function
REQ-013 SHALL accept a request in cycle t when start=1 and busy=0, latching mf, a and b; start while busy=1 SHALL be ignored with no effect.
REQ-014 SHALL implement the FSM IDLE -> RUN (exactly N cycles, one radix-2 step per cycle) -> FIX (one cycle: sign correction, hi/lo write) -> IDLE.
REQ-015 For MULT/MULTU/DIV/DIVU accepted in cycle t: busy=1 in cycles t+1..t+N+1; hi, lo and done=1 visible in cycle t+N+2 with busy=0.
REQ-016 MTHI/MTLO SHALL bypass RUN/FIX: hi (resp. lo) = a and done=1 in cycle t+1, busy stays 0, the other register is unchanged.
REQ-017 MULT/MULTU SHALL write the full 2N-bit two's-complement (resp. unsigned) product, upper half to hi and lower half to lo; no overflow indication.
REQ-018 DIV/DIVU SHALL write quotient to lo and remainder to hi; signed quotient truncates toward zero; remainder takes the dividend's sign.
REQ-019 Signed operations SHALL run on magnitudes in RUN and negate results in FIX as required.
REQ-020 Divide by zero (b=0, signed or unsigned) SHALL give lo = all ones, hi = a, err=0.
REQ-021 Signed MIN / -1 SHALL give lo = MIN, hi = 0, err=0.
REQ-022 A reserved mf SHALL be accepted, leave hi/lo unchanged, and pulse done=1 and err=1 in cycle t+1.
REQ-023 hi/lo SHALL change only in the done cycle or on reset; between operations they hold their values.
REQ-024 Inputs a, b and mf MAY change freely after the accept cycle without affecting the result.

Reset
REQ-025 reset=1 at a rising edge SHALL force state=IDLE, hi=0, lo=0, busy=0, done=0 and err=0 in the following cycle.
REQ-026 Reset during RUN or FIX SHALL abort the operation with no done pulse; start coincident with reset SHALL be ignored.

Configuration
REQ-027 Macro MDU_DIV_EN defined: DIV/DIVU SHALL behave per REQ-015 and REQ-018 to REQ-021.
REQ-028 MDU_DIV_EN undefined: no divider logic; DIV/DIVU SHALL be treated as reserved per REQ-022, and multiply/move behaviour SHALL be unchanged.

Structure
REQ-029 Package mdu_pkg SHALL hold the mf encoding enum (MF_MULT..MF_MTLO) and the FSM state enum (S_IDLE, S_RUN, S_FIX).
REQ-030 The design SHALL be a single module with a shared N-bit add/subtract datapath and a log2(N)+1-bit step counter; no sub-module.

Verification (N=32)
REQ-031 MULT a=00000007 b=FFFFFFFD -> at t+34: hi=FFFFFFFF, lo=FFFFFFEB, done=1; busy high for cycles t+1..t+33.
REQ-032 MULTU a=FFFFFFFF b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
REQ-033 DIV a=FFFFFFF9 b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; DIVU a=00000064 b=00000007 -> lo=0000000E, hi=00000002.
REQ-034 DIVU a=00000005 b=00000000 -> lo=FFFFFFFF, hi=00000005; DIV a=80000000 b=FFFFFFFF -> lo=80000000, hi=00000000.
REQ-035 MTHI a=12345678 -> in t+1: hi=12345678, done=1, lo unchanged; a second start during an active MULT -> ignored, and that MULT's result is unaffected.
REQ-036 reset asserted at t+10 of a MULT -> no done pulse, hi=lo=0, busy=0; with MDU_DIV_EN undefined, DIV -> done=1 and err=1 at t+1, hi/lo unchanged.
